// File: rtl/cascade_pkg.sv
// rtl/cascade_pkg.sv - shared types and widths for the window scheduler
// Holds the scheduler state enum, window coordinate widths and the {x,y} position type.
package cascade_pkg;

    localparam int IMG_WIDTH_DFLT  = 41;
    localparam int IMG_HEIGHT_DFLT = 50;

    localparam int W_X = $clog2(IMG_WIDTH_DFLT);
    localparam int W_Y = $clog2(IMG_HEIGHT_DFLT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [W_X-1:0] x;
        logic [W_Y-1:0] y;
    } win_pos_t;

endpackage

// File: rtl/window_scheduler_if.sv
// rtl/window_scheduler_if.sv - window, classifier and detection handshake bundle
// Groups the sweeper input, classifier issue, classifier result and detection output channels.
// slave  : scheduler view (accepts windows/results, drives issues/detections)
// master : environment view (sweeper, classifier and detection sink)
interface window_scheduler_if;

    logic                       win_in_valid;
    logic                       win_in_ready;
    logic [cascade_pkg::W_X-1:0] win_in_x;
    logic [cascade_pkg::W_Y-1:0] win_in_y;

    logic                       win_out_valid;
    logic                       win_out_ready;
    logic [cascade_pkg::W_X-1:0] win_out_x;
    logic [cascade_pkg::W_Y-1:0] win_out_y;

    logic                       res_valid;
    logic                       res_ready;
    logic                       res_detect;

    logic                       det_valid;
    logic                       det_ready;
    logic [cascade_pkg::W_X-1:0] det_x;
    logic [cascade_pkg::W_Y-1:0] det_y;

    modport slave (
        input  win_in_valid, win_in_x, win_in_y,
        output win_in_ready,
        output win_out_valid, win_out_x, win_out_y,
        input  win_out_ready,
        input  res_valid, res_detect,
        output res_ready,
        output det_valid, det_x, det_y,
        input  det_ready
    );

    modport master (
        output win_in_valid, win_in_x, win_in_y,
        input  win_in_ready,
        input  win_out_valid, win_out_x, win_out_y,
        output win_out_ready,
        output res_valid, res_detect,
        input  res_ready,
        input  det_valid, det_x, det_y,
        output det_ready
    );

endinterface

// File: rtl/pos_fifo.sv
// rtl/pos_fifo.sv - first-word-fall-through FIFO of in-flight window positions
// Ports: clk, rst (async active-low), push_i/data_i write side, pop_i/data_o read side
// (data_o shows the head entry whenever empty_o=0), full_o, empty_o.
// A pop on a full FIFO lets a push land in the same cycle.
module pos_fifo
    import cascade_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  win_pos_t data_i,
    input  logic     pop_i,
    output win_pos_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    win_pos_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/window_scheduler.sv
// rtl/window_scheduler.sv - issues a frame of windows to a classifier and forwards hits
// Ports: clk, rst (async active-low), start, busy, frame_done (1-cycle pulse),
// bus (window_scheduler_if.slave: sweeper in, classifier issue/result, detection out),
// det_count (16-bit saturating hit counter, only when SCHED_STATS_EN is defined).
// Optional feature macro: SCHED_STATS_EN.
module window_scheduler
    import cascade_pkg::*;
#(
    parameter int IMG_WIDTH    = IMG_WIDTH_DFLT,
    parameter int IMG_HEIGHT   = IMG_HEIGHT_DFLT,
    parameter int NUM_WINDOWS  = 64,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    window_scheduler_if.slave    bus
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]          det_count
`endif
);

    localparam int CW = $clog2(NUM_WINDOWS + 1);
    localparam logic [CW-1:0] NW_C    = CW'(NUM_WINDOWS);
    localparam logic [CW-1:0] NW_LAST = CW'(NUM_WINDOWS - 1);

    if (IMG_WIDTH > (1 << W_X) || IMG_HEIGHT > (1 << W_Y)) begin : g_bad_dims
        $error("window_scheduler: image dimensions do not fit W_X/W_Y");
    end

    sched_state_t   state_q, state_d;
    logic [CW-1:0]  issued_q, issued_d;
    logic [CW-1:0]  retired_q, retired_d;
    logic           det_valid_q, det_valid_d;
    win_pos_t       det_pos_q, det_pos_d;

    logic           issue_ok, push, pop;
    logic           fifo_full, fifo_empty;
    win_pos_t       fifo_wdata, fifo_rdata;

    // Issue path is a zero-latency pass-through gated by frame state and FIFO room.
    assign issue_ok          = (state_q == RUN) & ~fifo_full & (issued_q < NW_C);
    assign bus.win_out_valid = bus.win_in_valid & issue_ok;
    assign bus.win_in_ready  = bus.win_out_ready & issue_ok;
    assign bus.win_out_x     = bus.win_in_x;
    assign bus.win_out_y     = bus.win_in_y;
    assign push              = bus.win_in_valid & bus.win_out_ready & issue_ok;

    // A result is only taken when its position is known and the detection slot can take a hit.
    assign bus.res_ready = ~fifo_empty & (~det_valid_q | bus.det_ready);
    assign pop           = bus.res_valid & bus.res_ready;

    assign fifo_wdata = '{x: bus.win_in_x, y: bus.win_in_y};

    pos_fifo #(.DEPTH(MAX_INFLIGHT)) u_pos_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        retired_d = retired_q;
        if (push) issued_d = issued_q + 1'b1;
        if (pop && retired_q != NW_C) retired_d = retired_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    issued_d  = '0;
                    retired_d = '0;
                end
            end
            RUN:     if (push && issued_q == NW_LAST) state_d = DRAIN;
            DRAIN:   if (retired_q == NW_C && fifo_empty && !det_valid_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new hit overrides the clear so det_ready plus a hit gives back-to-back output.
    always_comb begin
        det_valid_d = det_valid_q;
        det_pos_d   = det_pos_q;
        if (pop && bus.res_detect) begin
            det_valid_d = 1'b1;
            det_pos_d   = fifo_rdata;
        end else if (bus.det_ready) begin
            det_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            issued_q    <= '0;
            retired_q   <= '0;
            det_valid_q <= 1'b0;
            det_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            det_valid_q <= det_valid_d;
            det_pos_q   <= det_pos_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign bus.det_valid = det_valid_q;
    assign bus.det_x     = det_pos_q.x;
    assign bus.det_y     = det_pos_q.y;

`ifdef SCHED_STATS_EN
    logic [15:0] det_count_q, det_count_d;

    always_comb begin
        det_count_d = det_count_q;
        if (state_q == IDLE && start) begin
            det_count_d = '0;
        end else if (det_valid_q && bus.det_ready && det_count_q != 16'hFFFF) begin
            det_count_d = det_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) det_count_q <= '0;
        else      det_count_q <= det_count_d;
    end

    assign det_count = det_count_q;
`endif

endmodule

// File: tb/tb_window_scheduler.sv
// tb/tb_window_scheduler.sv - scoreboard bench for window_scheduler (NUM_WINDOWS=6, MAX_INFLIGHT=2)
module tb_window_scheduler;
    import cascade_pkg::*;

    localparam int NW = 6;
    localparam int MI = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done;
`ifdef SCHED_STATS_EN
    logic [15:0] det_count;
`endif

    always #5 clk = ~clk;

    window_scheduler_if bus ();

    window_scheduler #(
        .IMG_WIDTH    (41),
        .IMG_HEIGHT   (50),
        .NUM_WINDOWS  (NW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
`ifdef SCHED_STATS_EN
        ,
        .det_count  (det_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    win_pos_t sweep_q[$];
    logic     res_pat[$];
    win_pos_t pos_model[$];
    win_pos_t exp_det[$];
    logic     res_en = 1'b0;
    int issue_cnt = 0, res_cnt = 0, det_seen = 0, fd_cnt = 0;
    int last_det_x = -1, last_det_y = -1;

    // Sweeper: presents the head of sweep_q
    initial begin
        bus.win_in_valid = 1'b0;
        bus.win_in_x = '0;
        bus.win_in_y = '0;
        forever begin
            @(posedge clk); #1;
            if (sweep_q.size() > 0) begin
                bus.win_in_valid = 1'b1;
                bus.win_in_x = sweep_q[0].x;
                bus.win_in_y = sweep_q[0].y;
            end else begin
                bus.win_in_valid = 1'b0;
            end
        end
    end

    // Classifier: returns the next queued result flag when enabled
    initial begin
        bus.res_valid = 1'b0;
        bus.res_detect = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.res_valid  = res_en && (res_pat.size() > 0);
            bus.res_detect = (res_pat.size() > 0) ? res_pat[0] : 1'b0;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        win_pos_t p;
        if (rst) begin
            if (bus.win_in_valid && bus.win_in_ready) begin
                check_eq("issue_valid", bus.win_out_valid, 1);
                check_eq("issue_x", bus.win_out_x, sweep_q[0].x);
                check_eq("issue_y", bus.win_out_y, sweep_q[0].y);
                pos_model.push_back(sweep_q[0]);
                void'(sweep_q.pop_front());
                issue_cnt++;
            end
            if (bus.res_valid && bus.res_ready) begin
                res_cnt++;
                if (pos_model.size() == 0) begin
                    check_eq("res_accept_nothing_inflight", pos_model.size(), 1);
                end else begin
                    p = pos_model.pop_front();
                    if (bus.res_detect) exp_det.push_back(p);
                end
                void'(res_pat.pop_front());
            end
            if (bus.det_valid && bus.det_ready) begin
                det_seen++;
                last_det_x = int'(bus.det_x);
                last_det_y = int'(bus.det_y);
                if (exp_det.size() == 0) begin
                    check_eq("det_unexpected", exp_det.size(), 1);
                end else begin
                    p = exp_det.pop_front();
                    check_eq("det_x", bus.det_x, p.x);
                    check_eq("det_y", bus.det_y, p.y);
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic clear_counts();
        issue_cnt = 0; res_cnt = 0; det_seen = 0; fd_cnt = 0;
        last_det_x = -1; last_det_y = -1;
    endtask

    task automatic add_win(input int x, input int y, input logic det);
        win_pos_t w;
        w.x = W_X'(x);
        w.y = W_Y'(y);
        sweep_q.push_back(w);
        res_pat.push_back(det);
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int n0;
        int k;
        n0 = fd_cnt;
        k = 0;
        while (fd_cnt == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_eq(tag, fd_cnt > n0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        bus.win_out_ready = 1'b0;
        bus.det_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_det_valid", bus.det_valid, 0);
        check_eq("rst_det_x", bus.det_x, 0);
        check_eq("rst_det_y", bus.det_y, 0);
        check_eq("rst_res_ready", bus.res_ready, 0);
        @(negedge clk); rst = 1'b1;

        // Plain frame, no hits
        clear_counts();
        bus.win_out_ready = 1'b1; bus.det_ready = 1'b1; res_en = 1'b1;
        for (int i = 0; i < NW; i++) add_win(i + 1, 2 * i, 1'b0);
        start_frame();
        check_eq("t1_busy_run", busy, 1);
        wait_frame("t1_frame_done_seen", 200);
        repeat (2) @(posedge clk); #1;
        check_eq("t1_issues", issue_cnt, NW);
        check_eq("t1_results", res_cnt, NW);
        check_eq("t1_dets", det_seen, 0);
        check_eq("t1_fd_once", fd_cnt, 1);
        check_eq("t1_busy_end", busy, 0);

        // Stalled classifier limits in-flight windows
        clear_counts();
        res_en = 1'b0;
        for (int i = 0; i < NW; i++) sweep_q.push_back('{x: W_X'(10 + i), y: W_Y'(i)});
        start_frame();
        repeat (10) @(posedge clk); #1;
        check_eq("t2_inflight_cap", issue_cnt, MI);
        check_eq("t2_in_ready_low", bus.win_in_ready, 0);
        res_pat.push_back(1'b0);
        res_en = 1'b1;
        k = 0;
        while (issue_cnt < MI + 1 && k < 20) begin @(posedge clk); k++; end
        repeat (4) @(posedge clk); #1;
        check_eq("t2_third_issue", issue_cnt, MI + 1);
        check_eq("t2_one_result", res_cnt, 1);
        for (int i = 0; i < NW - 1; i++) res_pat.push_back(1'b0);
        wait_frame("t2_frame_done_seen", 200);
        check_eq("t2_issues", issue_cnt, NW);

        // Single hit on the second window
        repeat (2) @(posedge clk);
        clear_counts();
        add_win(3, 4, 1'b0);
        add_win(5, 1, 1'b1);
        for (int i = 0; i < NW - 2; i++) add_win(7 + i, 7 + i, 1'b0);
        start_frame();
        wait_frame("t3_frame_done_seen", 200);
        check_eq("t3_dets", det_seen, 1);
        check_eq("t3_det_x", last_det_x, 5);
        check_eq("t3_det_y", last_det_y, 1);

        // Detection back-pressure
        repeat (2) @(posedge clk);
        clear_counts();
        bus.det_ready = 1'b0;
        add_win(1, 1, 1'b1);
        add_win(2, 2, 1'b1);
        for (int i = 0; i < NW - 2; i++) add_win(3 + i, 3 + i, 1'b0);
        start_frame();
        repeat (15) @(posedge clk); #1;
        check_eq("t4_det_valid", bus.det_valid, 1);
        check_eq("t4_det_x_hold", bus.det_x, 1);
        check_eq("t4_res_ready", bus.res_ready, 0);
        check_eq("t4_in_ready", bus.win_in_ready, 0);
        check_eq("t4_issues_full", issue_cnt, 3);
        repeat (5) @(posedge clk); #1;
        check_eq("t4_det_x_stable", bus.det_x, 1);
        check_eq("t4_det_y_stable", bus.det_y, 1);
        bus.det_ready = 1'b1;
        wait_frame("t4_frame_done_seen", 200);
        check_eq("t4_dets", det_seen, 2);
        check_eq("t4_last_x", last_det_x, 2);

        // Reset mid-DRAIN
        repeat (2) @(posedge clk);
        clear_counts();
        bus.det_ready = 1'b0;
        for (int i = 0; i < NW; i++) sweep_q.push_back('{x: W_X'(20 + i), y: W_Y'(30 + i)});
        res_pat.push_back(1'b0); res_pat.push_back(1'b0);
        res_pat.push_back(1'b0); res_pat.push_back(1'b1);
        start_frame();
        k = 0;
        while (issue_cnt < NW && k < 100) begin @(posedge clk); k++; end
        check_eq("t5_all_issued", issue_cnt, NW);
        repeat (3) @(posedge clk); #1;
        check_eq("t5_busy_drain", busy, 1);
        check_eq("t5_det_held", bus.det_valid, 1);
        #3 rst = 1'b0;
        #1;
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_det_valid", bus.det_valid, 0);
        check_eq("t5_rst_det_x", bus.det_x, 0);
        check_eq("t5_rst_frame_done", frame_done, 0);
        check_eq("t5_rst_res_ready", bus.res_ready, 0);
        sweep_q.delete(); res_pat.delete(); pos_model.delete(); exp_det.delete();
        n0 = fd_cnt;
        @(negedge clk); rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        check_eq("t5_no_frame_done", fd_cnt, n0);
        check_eq("t5_idle", busy, 0);
        clear_counts();
        bus.det_ready = 1'b1;
        add_win(11, 12, 1'b0);
        add_win(13, 14, 1'b0);
        add_win(15, 16, 1'b1);
        for (int i = 0; i < NW - 3; i++) add_win(17 + i, 20 + i, 1'b0);
        start_frame();
        wait_frame("t5_frame_done_seen", 200);
        check_eq("t5_issues", issue_cnt, NW);
        check_eq("t5_dets", det_seen, 1);
        check_eq("t5_det_x", last_det_x, 15);

`ifdef SCHED_STATS_EN
        // Hit statistics
        repeat (2) @(posedge clk);
        clear_counts();
        add_win(1, 2, 1'b1);
        add_win(2, 3, 1'b1);
        add_win(3, 4, 1'b0);
        add_win(4, 5, 1'b1);
        add_win(5, 6, 1'b1);
        add_win(6, 7, 1'b0);
        start_frame();
        wait_frame("t6_frame_done_seen", 200);
        repeat (2) @(posedge clk); #1;
        check_eq("t6_det_count", det_count, 4);
        start_frame();
        check_eq("t6_det_count_clear", det_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scheduler.md
WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 Parameters SHALL be: IMG_WIDTH=41, image width (pixels); IMG_HEIGHT=50, image height (pixels); NUM_WINDOWS=64, windows issued per frame; MAX_INFLIGHT=4, windows outstanding in the classifier.
REQ-002 Ports SHALL be: clk in 1, clock; rst in 1, asynchronous active-low reset; start in 1, begin frame; busy out 1, frame in progress; frame_done out 1, one-cycle end-of-frame pulse.
REQ-003 Window ports SHALL be: win_in_valid in 1 and win_in_ready out 1 from the sweeper; win_in_x in W_X and win_in_y in W_Y, window position.
REQ-004 Classifier issue ports SHALL be: win_out_valid out 1, win_out_ready in 1, win_out_x out W_X, win_out_y out W_Y.
REQ-005 Classifier result ports SHALL be: res_valid in 1, res_ready out 1, res_detect in 1, window hit flag.
REQ-006 Detection output ports SHALL be: det_valid out 1, det_ready in 1, det_x out W_X, det_y out W_Y.

Function
REQ-007 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-008 IDLE SHALL go to RUN on start=1 and clear the issued and retired counters; start SHALL be ignored in every other state.
REQ-009 RUN SHALL go to DRAIN in the cycle after the issue handshake that makes issued equal NUM_WINDOWS.
REQ-010 DRAIN SHALL go to DONE when retired equals NUM_WINDOWS, the position FIFO is empty and det_valid=0.
REQ-011 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE.
REQ-012 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-013 Issue is a combinational pass-through: win_out_valid = win_in_valid & RUN & !fifo_full & (issued<NUM_WINDOWS); win_in_ready = win_out_ready & the same qualifiers; win_out_x/y = win_in_x/y, zero latency.
REQ-014 Each issue handshake SHALL push {x,y} into the position FIFO and increment issued.
REQ-015 res_ready SHALL be 1 only when the FIFO is non-empty and (det_valid=0 or det_ready=1); results with an empty FIFO SHALL NOT be accepted.
REQ-016 A result handshake SHALL pop the FIFO and increment retired; with res_detect=1 it SHALL load det_x/y from the popped entry and set det_valid on the next cycle; with res_detect=0 the entry SHALL be dropped.
REQ-017 det_valid SHALL hold, with det_x/y stable, until det_ready=1; a new detection in the same cycle as det_ready=1 SHALL give back-to-back output with no bubble.
REQ-018 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged; a pop on a full FIFO SHALL allow a push in the same cycle.
REQ-019 Counters SHALL be $clog2(NUM_WINDOWS+1) bits wide and SHALL never exceed NUM_WINDOWS.

Reset
REQ-020 rst=0 SHALL asynchronously force IDLE, clear both counters, empty the FIFO, and drive busy, frame_done and det_valid to 0 and det_x/y to 0; any in-flight frame SHALL be abandoned.

Configuration
REQ-021 With SCHED_STATS_EN defined, the block SHALL add the output det_count, 16 bits, which clears on start, increments on each det handshake and saturates at 16'hFFFF.
REQ-022 Without SCHED_STATS_EN, the det_count port and its logic SHALL be absent.

Structure
REQ-023 Package cascade_pkg SHALL hold the state enum sched_state_t, the W_X and W_Y width constants, and the typedef win_pos_t {x,y}.
REQ-024 The position FIFO SHALL be a separate sub-module pos_fifo: synchronous, depth MAX_INFLIGHT, first-word-fall-through, with full and empty flags.

Verification (NUM_WINDOWS=6, MAX_INFLIGHT=2)
REQ-025 Reset, then start, then 6 windows with ready held high and all res_detect=0 -> 6 issues, 0 det_valid, frame_done pulses once, busy falls to 0.
REQ-026 Classifier never returns a result -> exactly 2 issues, then win_in_ready=0; one result returned -> third issue accepted.
REQ-027 Windows (3,4) and (5,1), only the second with res_detect=1 -> exactly one detection with det_x=5, det_y=1.
REQ-028 det_ready held low across two hits -> first detection holds stable, res_ready=0, FIFO stays full; det_ready released -> both detections emitted in order.
REQ-029 rst pulsed low mid-DRAIN -> IDLE immediately, det_valid=0, no frame_done; a following start runs a complete frame.
REQ-030 With SCHED_STATS_EN, 4 hits in a frame -> det_count=4; the next start clears it to 0.
